// File: rtl/moore_mod_counter.sv
// Parametrised Moore modulo counter: runtime terminal/decode values, up/down,
// enable, parallel load and a one-shot mode that parks in DONE until re-armed.
module moore_mod_counter #(
   parameter int               WIDTH       = 2,
   parameter logic [WIDTH-1:0] RESET_TERM  = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] RESET_MATCH = WIDTH'(2)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             dir,
   input  logic             oneshot,
   input  logic             start,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] mod_val,
   input  logic [WIDTH-1:0] match_val,
   output logic [WIDTH-1:0] count,
   output logic             out,
   output logic             wrap,
   output logic             done
);

   typedef enum logic {RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] term_q;
   logic [WIDTH-1:0] match_q;
   logic             at_bound;

   // A count outside 0..term_q (e.g. after a load) is treated as the boundary,
   // so the counter never relies on modular overflow.
   always_comb begin
      at_bound = 1'b0;
      if (dir) at_bound = (count >= term_q);
      else     at_bound = (count == '0) || (count > term_q);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count   <= '0;
         term_q  <= RESET_TERM;
         match_q <= RESET_MATCH;
         state   <= RUN;
         wrap    <= 1'b0;
      end else if (load) begin
         count   <= load_val;
         term_q  <= mod_val;
         match_q <= match_val;
         state   <= RUN;
         wrap    <= 1'b0;
      end else if (start && state == DONE) begin
         count   <= dir ? '0 : mod_val;
         term_q  <= mod_val;
         match_q <= match_val;
         state   <= RUN;
         wrap    <= 1'b0;
      end else if (en && state == RUN) begin
         if (at_bound) begin
            wrap <= 1'b1;
            if (oneshot) begin
               state <= DONE;
            end else begin
               count   <= dir ? '0 : mod_val;
               term_q  <= mod_val;
               match_q <= match_val;
            end
         end else begin
            wrap  <= 1'b0;
            count <= dir ? count + WIDTH'(1) : count - WIDTH'(1);
         end
      end else begin
         wrap <= 1'b0;
      end
   end

   assign out  = (count == match_q);
   assign done = (state == DONE);

endmodule

// File: tb/tb_moore_mod_counter.sv
// Bench for moore_mod_counter: directed vector table, legacy 2-bit sequence,
// and a randomized run against a behavioural model.
module tb_moore_mod_counter;

   logic       clk = 1'b0;
   logic       reset_n, en, dir, oneshot, start, load;
   logic [3:0] load_val, mod_val, match_val;
   logic [3:0] count;
   logic       out, wrap, done;
   logic [1:0] count2;
   logic       out2, wrap2, done2;
   logic [1:0] load_val2, mod_val2, match_val2;

   assign load_val2  = load_val[1:0];
   assign mod_val2   = mod_val[1:0];
   assign match_val2 = match_val[1:0];

   always #5 clk = ~clk;

   moore_mod_counter #(.WIDTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .oneshot(oneshot),
      .start(start), .load(load), .load_val(load_val), .mod_val(mod_val),
      .match_val(match_val), .count(count), .out(out), .wrap(wrap), .done(done)
   );

   // Default parameters: the legacy 2-bit, 4-state counter.
   moore_mod_counter legacy (
      .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .oneshot(oneshot),
      .start(start), .load(load), .load_val(load_val2), .mod_val(mod_val2),
      .match_val(match_val2), .count(count2), .out(out2), .wrap(wrap2), .done(done2)
   );

   typedef struct {
      logic       r, e, di, os, st, ld;
      logic [3:0] lv, mv, xv;
      logic [3:0] c;
      logic       o, w, d;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   // behavioural model state (plain integers)
   int m_count, m_term, m_match;
   bit m_done, m_wrap;

   task automatic add(input bit r, e, di, os, st, ld, input int lv, mv, xv,
                      input int c, input bit o, w, d);
      vec_t v;
      v.r = r; v.e = e; v.di = di; v.os = os; v.st = st; v.ld = ld;
      v.lv = 4'(lv); v.mv = 4'(mv); v.xv = 4'(xv);
      v.c = 4'(c); v.o = o; v.w = w; v.d = d;
      tbl.push_back(v);
   endtask

   task automatic drive(input bit r, e, di, os, st, ld, input logic [3:0] lv, mv, xv);
      reset_n = r; en = e; dir = di; oneshot = os; start = st; load = ld;
      load_val = lv; mod_val = mv; match_val = xv;
   endtask

   task automatic check(input string name, input int c, input bit o, w, d,
                        input int ec, input bit eo, ew, ed);
      n_vec++;
      if (c != ec || o != eo || w != ew || d != ed) begin
         n_err++;
         $display("FAIL %s: got count=%0d out=%0b wrap=%0b done=%0b, expected count=%0d out=%0b wrap=%0b done=%0b",
                  name, c, o, w, d, ec, eo, ew, ed);
      end
   endtask

   // Next-state per the counter rules, from the currently driven inputs.
   task automatic model_edge();
      int mv, lim;
      mv = int'(mod_val);
      if (!reset_n) begin
         m_count = 0; m_term = 15; m_match = 2; m_done = 0; m_wrap = 0;
      end else if (load) begin
         m_count = int'(load_val); m_term = mv; m_match = int'(match_val);
         m_done = 0; m_wrap = 0;
      end else if (start && m_done) begin
         m_count = dir ? 0 : mv; m_term = mv; m_match = int'(match_val);
         m_done = 0; m_wrap = 0;
      end else if (en && !m_done) begin
         lim = dir ? m_term : 0;
         if (dir ? (m_count < lim) : (m_count > 0 && m_count <= m_term)) begin
            m_count = m_count + (dir ? 1 : -1);
            m_wrap  = 0;
         end else begin
            m_wrap = 1;
            if (oneshot) m_done = 1;
            else begin
               m_count = dir ? 0 : mv; m_term = mv; m_match = int'(match_val);
            end
         end
      end else begin
         m_wrap = 0;
      end
   endtask

   initial begin
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0);

      // reset: match_q=2 so out=0 at count 0
      add(0,0,1,0,0,0, 0,0,0,  0,0,0,0);
      add(0,0,1,0,0,0, 0,0,0,  0,0,0,0);
      // mod_val change mid-period is deferred to the wrap
      add(1,0,1,0,0,1, 0,9,7,  0,0,0,0);
      for (int c = 1; c <= 4; c++) add(1,1,1,0,0,0, 0,9,7, c,(c==7),0,0);
      for (int c = 5; c <= 9; c++) add(1,1,1,0,0,0, 0,5,7, c,(c==7),0,0);
      add(1,1,1,0,0,0, 0,5,7,  0,0,1,0);
      for (int c = 1; c <= 5; c++) add(1,1,1,0,0,0, 0,5,7, c,0,0,0);
      add(1,1,1,0,0,0, 0,5,7,  0,0,1,0);
      // down count from a load
      add(1,0,0,0,0,1, 2,5,7,  2,0,0,0);
      add(1,1,0,0,0,0, 0,5,7,  1,0,0,0);
      add(1,1,0,0,0,0, 0,5,7,  0,0,0,0);
      add(1,1,0,0,0,0, 0,5,7,  5,0,1,0);
      add(1,1,0,0,0,0, 0,5,7,  4,0,0,0);
      // one-shot up, done, start re-arm, start ignored in RUN
      add(1,0,1,1,0,1, 0,3,3,  0,0,0,0);
      add(1,1,1,1,0,0, 0,3,3,  1,0,0,0);
      add(1,1,1,1,0,0, 0,3,3,  2,0,0,0);
      add(1,1,1,1,0,0, 0,3,3,  3,1,0,0);
      add(1,1,1,1,0,0, 0,3,3,  3,1,1,1);
      add(1,1,1,1,0,0, 0,3,3,  3,1,0,1);
      add(1,1,1,1,0,0, 0,3,3,  3,1,0,1);
      add(1,0,1,1,1,0, 0,3,3,  0,0,0,0);
      add(1,1,1,1,1,0, 0,3,3,  1,0,0,0);
      // one-shot with term 0, then start counting down reloads mod_val
      add(1,0,1,1,0,1, 0,0,0,  0,1,0,0);
      add(1,1,1,1,0,0, 0,0,0,  0,1,1,1);
      add(1,0,0,1,1,0, 0,6,6,  6,1,0,0);
      // out-of-range load counting up, then en=0 holds
      add(1,0,1,0,0,1, 12,5,7, 12,0,0,0);
      add(1,1,1,0,0,0, 0,5,7,  0,0,1,0);
      for (int k = 0; k < 3; k++) add(1,0,1,0,0,0, 0,5,7, 0,0,0,0);
      // out-of-range load counting down
      add(1,0,0,0,0,1, 12,5,7, 12,0,0,0);
      add(1,1,0,0,0,0, 0,5,7,  5,0,1,0);
      add(1,1,0,0,0,0, 0,5,7,  4,0,0,0);
      // term 0 free-run: wrap every enabled cycle
      add(1,0,1,0,0,1, 0,0,0,  0,1,0,0);
      add(1,1,1,0,0,0, 0,0,0,  0,1,1,0);
      add(1,1,1,0,0,0, 0,0,0,  0,1,1,0);
      // reset beats a simultaneous load
      add(1,0,1,0,0,1, 7,9,7,  7,1,0,0);
      add(0,1,1,0,0,1, 3,9,7,  0,0,0,0);

      #1;
      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].e, tbl[i].di, tbl[i].os, tbl[i].st, tbl[i].ld,
               tbl[i].lv, tbl[i].mv, tbl[i].xv);
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), int'(count), out, wrap, done,
               int'(tbl[i].c), tbl[i].o, tbl[i].w, tbl[i].d);
      end

      // legacy sequence 00,01,10,11,00 with out only at 10
      drive(0, 0, 1, 0, 0, 0, 0, 3, 2);
      repeat (2) @(posedge clk);
      #1;
      check("legacy_reset", int'(count2), out2, wrap2, done2, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 0, 0, 3, 2);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         check($sformatf("legacy%0d", k), int'(count2), out2, wrap2, done2,
               k % 4, (k % 4) == 2, (k % 4) == 0, 0);
      end

      // randomized run against the model
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
      model_edge();
      @(posedge clk); #1;
      check("rand_reset", int'(count), out, wrap, done,
            m_count, m_count == m_match, m_wrap, m_done);
      for (int k = 0; k < 2000; k++) begin
         drive($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
               1'($urandom), $urandom_range(0, 3) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
               4'($urandom), 4'($urandom), 4'($urandom));
         model_edge();
         @(posedge clk); #1;
         check($sformatf("rand%0d", k), int'(count), out, wrap, done,
               m_count, m_count == m_match, m_wrap, m_done);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
